fc1_ifm_buffer: RTL and testbench
=================================

Name: fc1_ifm_buffer

Overview:
- Feed-side responder for the FC1 layer. It collects the 120 flattened activations written by the preceding pooling/flatten stage.
- Once the previous stage signals completion, it starts FC1 and then serves one word per FC1 read request on FC1's data_in_from_previous input.
- The buffer is released when FC1 signals end, and the release is passed back upstream.
- It implements the consumer-facing ends of the start/end/enable handshakes that FC1 drives on its previous-layer side.

Parameters:
DATA_WIDTH, 32, activation word width
IFM_DEPTH, 120, words per FC1 input vector
ADDR_W, $clog2(IFM_DEPTH), buffer address width

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
data_in_from_previous  input  DATA_WIDTH  activation word from upstream stage
enable_write_current  input  1  upstream write strobe, one word per cycle
start_from_previous  input  1  pulse: upstream finished writing the vector
end_to_previous  output  1  pulse: buffer freed, upstream may refill
start_to_next  output  1  pulse: vector ready, FC1 may start
enable_read_current  input  1  FC1 read request (FC1 output of same name)
data_out_to_next  output  DATA_WIDTH  word to FC1 data_in_from_previous
end_from_next  input  1  pulse from FC1 end_to_previous: FC1 finished with the vector
busy  output  1  high outside FILL state
wr_count  output  ADDR_W+1  words accepted in current fill
overflow  output  1  sticky: write rejected (full or wrong state)

Behaviour:
- Reset (reset=0, async): state=FILL, wr_ptr=0, rd_ptr=0, wr_count=0, data_out_to_next=0, and all pulses, busy and overflow=0.
- FSM states: FILL, START, SERVE, RELEASE.
- FILL:
  - enable_write_current with wr_count<IFM_DEPTH writes data at wr_ptr, then increments wr_ptr and wr_count.
  - A write when wr_count==IFM_DEPTH is dropped and sets overflow.
  - start_from_previous moves to START, even when wr_count<IFM_DEPTH. Unwritten words hold stale RAM contents.
  - A write and start_from_previous in the same cycle: the write is accepted first, then the transition happens.
- START:
  - start_to_next=1 for exactly one cycle, rd_ptr=0, then go to SERVE.
- SERVE:
  - enable_read_current=1 puts RAM[rd_ptr] on data_out_to_next on the next rising edge (1-cycle read latency) and increments rd_ptr.
  - rd_ptr wraps from IFM_DEPTH-1 to 0.
  - data_out_to_next holds its value when no read occurs.
  - Any enable_write_current is dropped and sets overflow.
- end_from_next:
  - Acted on in SERVE only; ignored in all other states.
  - If it coincides with enable_read_current, the read completes and end still wins: go to RELEASE.
- RELEASE:
  - end_to_previous=1 for one cycle; clear wr_ptr, wr_count and rd_ptr; return to FILL.
  - overflow is not cleared here; only reset clears it.
- Reset mid-operation aborts any state immediately. RAM contents are not cleared.
- Back-to-back vectors: a start_from_previous arriving before RELEASE is not queued. Upstream must wait for end_to_previous.

Decomposition:
- Shared package fc_pkg: DATA_WIDTH default, FC1_IFM_DEPTH=120, FC1_NUM_NEURONS=84, and the state encoding (FILL=2'd0, START=2'd1, SERVE=2'd2, RELEASE=2'd3).
- One sub-module: fc1_ifm_ram, a simple dual-port RAM (sync write port, registered sync read port, IFM_DEPTH x DATA_WIDTH).
- FSM and pointers live in the top module.

Test Plan:
- Fill: write values 1..120, pulse start_from_previous.
  - Required: start_to_next pulses once 1 cycle later, busy=1, wr_count=120.
- Stream: hold enable_read_current for 120 cycles.
  - Required: data_out_to_next shows 1..120, each 1 cycle after its request.
  - A 121st read returns 1 (wrap).
- Release: pulse end_from_next in SERVE.
  - Required: end_to_previous pulses once, busy=0, wr_count=0.
  - A new fill with 200..319 streams back correctly.
- Overflow: write 121 words in FILL, plus 1 write during SERVE.
  - Required: overflow=1 after the 121st write; RAM[0] still holds 1.
  - The vector is unaffected.
- Corner events:
  - Assert end_from_next together with enable_read_current: the read data appears and RELEASE follows.
  - Assert end_from_next in FILL: ignored.
- Reset: drive reset=0 mid-SERVE (rd_ptr=50).
  - Required: all outputs 0 asynchronously, state FILL.
  - A subsequent fill/stream starts reading at address 0.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared FC-layer constants and the feed-buffer state encoding.
package fc_pkg;

    localparam int FC_DATA_WIDTH   = 32;
    localparam int FC1_IFM_DEPTH   = 120;
    localparam int FC1_NUM_NEURONS = 84;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        START   = 2'd1,
        SERVE   = 2'd2,
        RELEASE = 2'd3
    } fc_buf_state_e;

endpackage

// File: rtl/fc1_ifm_ram.sv
// Simple dual-port activation RAM: sync write port, registered sync read port.
module fc1_ifm_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 120,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register holds its value between reads; only it is reset, not the array.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fc1_ifm_buffer.sv
// FC1 input-vector buffer: fills from the flatten stage, serves FC1 reads, hands the
// buffer back upstream when FC1 is done.
module fc1_ifm_buffer
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int IFM_DEPTH  = FC1_IFM_DEPTH,
    parameter int ADDR_W     = $clog2(IFM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in_from_previous,
    input  logic                  enable_write_current,
    input  logic                  start_from_previous,
    output logic                  end_to_previous,
    output logic                  start_to_next,
    input  logic                  enable_read_current,
    output logic [DATA_WIDTH-1:0] data_out_to_next,
    input  logic                  end_from_next,
    output logic                  busy,
    output logic [ADDR_W:0]       wr_count,
    output logic                  overflow
);

    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(IFM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IFM_DEPTH - 1);

    fc_buf_state_e     state_d, state_q;
    logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [ADDR_W:0]   wr_count_d, wr_count_q;
    logic              overflow_d, overflow_q;
    logic              start_d, start_q;
    logic              end_d, end_q;
    logic              ram_we, ram_re;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_count_d = wr_count_q;
        overflow_d = overflow_q;
        start_d    = 1'b0;
        end_d      = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        // Writes are only legal in FILL; anywhere else they are dropped and flagged.
        if (enable_write_current && state_q != FILL) overflow_d = 1'b1;

        case (state_q)
            FILL: begin
                if (enable_write_current) begin
                    if (wr_count_q < FULL_CNT) begin
                        ram_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        wr_count_d = wr_count_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (start_from_previous) begin
                    state_d = START;
                    start_d = 1'b1;
                end
            end
            START: begin
                rd_ptr_d = '0;
                state_d  = SERVE;
            end
            SERVE: begin
                if (enable_read_current) begin
                    ram_re   = 1'b1;
                    rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
                end
                // A coincident read still completes; end takes the state.
                if (end_from_next) begin
                    state_d = RELEASE;
                    end_d   = 1'b1;
                end
            end
            RELEASE: begin
                wr_ptr_d   = '0;
                wr_count_d = '0;
                rd_ptr_d   = '0;
                state_d    = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_count_q <= '0;
            overflow_q <= 1'b0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_count_q <= wr_count_d;
            overflow_q <= overflow_d;
            start_q    <= start_d;
            end_q      <= end_d;
        end
    end

    fc1_ifm_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IFM_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (data_in_from_previous),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (data_out_to_next)
    );

    assign start_to_next   = start_q;
    assign end_to_previous = end_q;
    assign busy            = (state_q != FILL);
    assign wr_count        = wr_count_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_fc1_ifm_buffer.sv
// Directed + randomized bench for fc1_ifm_buffer against an array/index reference model.
module tb_fc1_ifm_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 120;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic          we, start_in, re, end_in;
    logic          end_out, start_out, busy, ovf;
    logic [DW-1:0] dout;
    logic [AW:0]   wcnt;

    always #5 clk = ~clk;

    fc1_ifm_buffer #(.DATA_WIDTH(DW), .IFM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .data_in_from_previous (din),
        .enable_write_current  (we),
        .start_from_previous   (start_in),
        .end_to_previous       (end_out),
        .start_to_next         (start_out),
        .enable_read_current   (re),
        .data_out_to_next      (dout),
        .end_from_next         (end_in),
        .busy                  (busy),
        .wr_count              (wcnt),
        .overflow              (ovf)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: buffer contents, fill count, read index, sticky flag, held output.
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_cnt;
    int            ref_rd;
    bit            ref_ovf;
    logic [DW-1:0] ref_dout;
    logic [DW-1:0] vec [DEPTH+1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n, input bit start_last);
        for (int i = 0; i < n; i++) begin
            we = 1'b1;
            din = vec[i];
            start_in = start_last && (i == n - 1);
            @(negedge clk);
            if (ref_cnt < DEPTH) begin
                ref_mem[ref_cnt] = vec[i];
                ref_cnt++;
            end else begin
                ref_ovf = 1'b1;
            end
            chk("fill_wr_count", 64'(wcnt), 64'(ref_cnt));
            chk("fill_overflow", 64'(ovf), 64'(ref_ovf));
        end
        we = 1'b0;
        start_in = 1'b0;
        if (!start_last) begin
            start_in = 1'b1;
            @(negedge clk);
            start_in = 1'b0;
        end
        chk("start_pulse", 64'(start_out), 64'(1));
        chk("busy_start", 64'(busy), 64'(1));
        chk("wr_count_start", 64'(wcnt), 64'(ref_cnt));
        @(negedge clk);
        chk("start_once", 64'(start_out), 64'(0));
        ref_rd = 0;
    endtask

    task automatic stream(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            re = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (re) begin
                ref_dout = ref_mem[ref_rd];
                ref_rd = (ref_rd + 1) % DEPTH;
            end
            chk("rd_data", 64'(dout), 64'(ref_dout));
        end
        re = 1'b0;
        chk("busy_serve", 64'(busy), 64'(1));
    endtask

    task automatic release_vec(input bit with_read);
        end_in = 1'b1;
        re = with_read;
        @(negedge clk);
        if (with_read) begin
            ref_dout = ref_mem[ref_rd];
            ref_rd = (ref_rd + 1) % DEPTH;
        end
        chk("end_rd_data", 64'(dout), 64'(ref_dout));
        chk("end_pulse", 64'(end_out), 64'(1));
        chk("busy_release", 64'(busy), 64'(1));
        end_in = 1'b0;
        re = 1'b0;
        @(negedge clk);
        ref_cnt = 0;
        chk("end_once", 64'(end_out), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("wr_count_clr", 64'(wcnt), 64'(0));
        chk("overflow_kept", 64'(ovf), 64'(ref_ovf));
    endtask

    initial begin
        reset = 1'b0;
        din = '0;
        we = 1'b0;
        start_in = 1'b0;
        re = 1'b0;
        end_in = 1'b0;
        ref_cnt = 0;
        ref_rd = 0;
        ref_ovf = 1'b0;
        ref_dout = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_wr_count", 64'(wcnt), 64'(0));
        chk("rst_overflow", 64'(ovf), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_start", 64'(start_out), 64'(0));
        chk("rst_end", 64'(end_out), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        // Vector 1..120, stream with wrap, release
        for (int i = 0; i < DEPTH; i++) vec[i] = DW'(i + 1);
        fill(DEPTH, 1'b0);
        stream(DEPTH + 1, 1'b0);
        chk("wrap_first", 64'(dout), 64'(1));
        stream(10, 1'b1);
        release_vec(1'b0);

        // end_from_next while filling is ignored
        end_in = 1'b1;
        @(negedge clk);
        end_in = 1'b0;
        chk("fill_end_ignored", 64'(end_out), 64'(0));
        chk("fill_end_busy", 64'(busy), 64'(0));
        chk("fill_end_cnt", 64'(wcnt), 64'(0));

        // Vector 200..319, last write coincides with start; end coincides with a read
        for (int i = 0; i < DEPTH; i++) vec[i] = DW'(200 + i);
        fill(DEPTH, 1'b1);
        stream(DEPTH, 1'b0);
        stream(20, 1'b1);
        release_vec(1'b1);

        // Overflow: 121 writes in FILL plus one during SERVE
        for (int i = 0; i <= DEPTH; i++) vec[i] = $urandom;
        fill(DEPTH + 1, 1'b0);
        chk("ovf_after_121", 64'(ovf), 64'(1));
        we = 1'b1;
        din = $urandom;
        @(negedge clk);
        we = 1'b0;
        ref_ovf = 1'b1;
        chk("ovf_serve_write", 64'(ovf), 64'(1));
        stream(1, 1'b0);
        chk("ovf_ram0_intact", 64'(dout), 64'(vec[0]));
        stream(DEPTH + 5, 1'b1);
        release_vec(1'b0);

        // Async reset in the middle of SERVE
        for (int i = 0; i < DEPTH; i++) vec[i] = $urandom;
        fill(DEPTH, 1'b0);
        stream(50, 1'b0);
        #2 reset = 1'b0;
        #1;
        ref_cnt = 0;
        ref_rd = 0;
        ref_ovf = 1'b0;
        ref_dout = '0;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_dout", 64'(dout), 64'(0));
        chk("arst_overflow", 64'(ovf), 64'(0));
        chk("arst_wr_count", 64'(wcnt), 64'(0));
        chk("arst_start", 64'(start_out), 64'(0));
        chk("arst_end", 64'(end_out), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Partial fill after reset: reads restart at address 0
        for (int i = 0; i < DEPTH; i++) vec[i] = $urandom;
        fill(60, 1'b0);
        stream(10, 1'b0);
        chk("post_rst_addr9", 64'(dout), 64'(vec[9]));
        release_vec(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
